mac_tcdm_port_merger: RTL and testbench

- Sits directly downstream of the MAC accelerator's MP TCDM master ports.
- Merges them onto a single TCDM master port towards the cluster interconnect, using round-robin arbitration.
- Returns each response to the port that issued the request. Responses are in order; an index FIFO tracks the outstanding transactions.
- Lets the accelerator be instantiated where only one interconnect port is available.

---
 rtl/mac_tcdm_port_merger.sv | 138 +++++++++++++
 tb/tb_mac_tcdm_port_merger.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_tcdm_port_merger.sv
// mac_tcdm_port_merger
// Merges MP upstream TCDM master ports of the MAC accelerator onto a single
// TCDM master port using round-robin arbitration. Responses come back in
// order; an index FIFO remembers which upstream port issued each granted
// request so the response can be routed back to it.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_req/in_gnt       per-port request / grant
//   in_add/in_wen/in_be/in_data   per-port request payload
//   in_r_data           read data, broadcast to every port
//   in_r_valid          per-port response valid (only the owning port)
//   out_req/out_gnt     merged downstream request / grant
//   out_add/out_wen/out_be/out_data  merged downstream payload
//   out_r_data/out_r_valid           downstream response
//   busy_o              transactions outstanding
//   err_o               sticky: response arrived with nothing outstanding
module mac_tcdm_port_merger #(
   parameter int unsigned MP        = 4,
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [MP-1:0]                in_req,
   output logic [MP-1:0]                in_gnt,
   input  logic [MP-1:0][AW-1:0]        in_add,
   input  logic [MP-1:0]                in_wen,
   input  logic [MP-1:0][DW/8-1:0]      in_be,
   input  logic [MP-1:0][DW-1:0]        in_data,
   output logic [MP-1:0][DW-1:0]        in_r_data,
   output logic [MP-1:0]                in_r_valid,
   output logic                         out_req,
   input  logic                         out_gnt,
   output logic [AW-1:0]                out_add,
   output logic                         out_wen,
   output logic [DW/8-1:0]              out_be,
   output logic [DW-1:0]                out_data,
   input  logic [DW-1:0]                out_r_data,
   input  logic                         out_r_valid,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1;
   localparam int unsigned FP_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

   logic [PTR_W-1:0] rr_ptr_q;
   logic [PTR_W-1:0] sel;
   logic [PTR_W-1:0] cand;
   logic             found;
   logic             any_req;
   logic             full;
   logic             hs;
   logic             pop;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] fifo_q [MAX_OUTST];
   logic [FP_W-1:0]  wr_ptr_q;
   logic [FP_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             err_q;

   function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
      return (p == FP_W'(MAX_OUTST - 1)) ? '0 : p + FP_W'(1);
   endfunction

   // Round-robin search starting at rr_ptr, wrapping modulo MP.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MP; i++) begin
         cand = PTR_W'((32'(rr_ptr_q) + i) % MP);
         if (!found && in_req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign any_req = |in_req;
   // No bypass: a pop in the same cycle does not free a slot until next cycle.
   assign full    = (count_q == CNT_W'(MAX_OUTST));
   assign out_req = any_req && !full;
   assign hs      = out_req && out_gnt;
   assign pop     = out_r_valid && (count_q != '0);
   assign head    = fifo_q[rd_ptr_q];
   assign busy_o  = (count_q != '0);
   assign err_o   = err_q;

   always_comb begin
      out_add  = '0;
      out_wen  = 1'b0;
      out_be   = '0;
      out_data = '0;
      if (any_req) begin
         out_add  = in_add[sel];
         out_wen  = in_wen[sel];
         out_be   = in_be[sel];
         out_data = in_data[sel];
      end
   end

   always_comb begin
      in_gnt     = '0;
      in_r_valid = '0;
      if (hs) in_gnt[sel] = 1'b1;
      if (pop) in_r_valid[head] = 1'b1;
      for (int unsigned p = 0; p < MP; p++) in_r_data[p] = out_r_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (hs) begin
            rr_ptr_q <= (sel == PTR_W'(MP - 1)) ? '0 : sel + PTR_W'(1);
            wr_ptr_q <= fifo_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= fifo_inc(rd_ptr_q);
         if (hs && !pop) count_q <= count_q + CNT_W'(1);
         else if (pop && !hs) count_q <= count_q - CNT_W'(1);
         if (out_r_valid && (count_q == '0)) err_q <= 1'b1;
      end
   end

   // Index storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (hs) fifo_q[wr_ptr_q] <= sel;
   end

endmodule

// File: tb/tb_mac_tcdm_port_merger.sv
module tb_mac_tcdm_port_merger;
   localparam int MP = 4, MAX_OUTST = 4, AW = 32, DW = 32, BW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_i;
   logic [MP-1:0]           in_req;
   logic [MP-1:0]           in_gnt;
   logic [MP-1:0][AW-1:0]   in_add;
   logic [MP-1:0]           in_wen;
   logic [MP-1:0][BW-1:0]   in_be;
   logic [MP-1:0][DW-1:0]   in_data;
   logic [MP-1:0][DW-1:0]   in_r_data;
   logic [MP-1:0]           in_r_valid;
   logic                    out_req, out_gnt, out_wen, out_r_valid, busy_o, err_o;
   logic [AW-1:0]           out_add;
   logic [BW-1:0]           out_be;
   logic [DW-1:0]           out_data, out_r_data;

   mac_tcdm_port_merger #(.MP(MP), .MAX_OUTST(MAX_OUTST), .AW(AW), .DW(DW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
      .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
      .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
      .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
      .out_r_valid(out_r_valid), .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct { int port; logic [DW-1:0] data; } sb_t;
   typedef struct { int due;  logic [DW-1:0] data; } rsp_t;

   sb_t  sb_q[$];
   rsp_t rsp_q[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;
   bit   mdl_on = 0, spur = 0, err_m = 0;
   int   rr_m = 0, outst = 0, last_due = 0, lat_min = 1, lat_max = 1;
   bit [MP-1:0] granted = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Round-robin rule: first requesting port at or after ptr, modulo MP.
   function automatic int rr_pick(input logic [MP-1:0] r, input int ptr);
      for (int i = 0; i < MP; i++) if (r[(ptr + i) % MP]) return (ptr + i) % MP;
      return -1;
   endfunction

   // Reference model: checks the request side and queues expected responses.
   always @(negedge clk) begin
      int s, lat, due;
      bit any, ereq;
      logic [MP-1:0] eg;
      logic [DW-1:0] d;
      if (mdl_on) begin
         any  = |in_req;
         ereq = any && (outst < MAX_OUTST);
         s    = rr_pick(in_req, rr_m);
         eg   = '0;
         if (ereq && out_gnt) eg[s] = 1'b1;
         chk("out_req", out_req, ereq);
         chk("in_gnt", in_gnt, eg);
         chk("busy_o", busy_o, outst != 0);
         chk("err_o", err_o, err_m);
         if (ereq)
            chk("payload", {out_add, out_wen, out_be, out_data},
                {in_add[s], in_wen[s], in_be[s], in_data[s]});
         else if (!any)
            chk("idle_payload", {out_add, out_wen, out_be, out_data}, '0);
         if (out_r_valid && outst == 0) begin
            chk("spurious_rvalid", in_r_valid, '0);
            err_m = 1'b1;
         end else if (out_r_valid) begin
            outst--;
         end
         if (ereq && out_gnt) begin
            d   = $urandom;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            sb_q.push_back('{port: s, data: d});
            rsp_q.push_back('{due: due, data: d});
            rr_m = (s + 1) % MP;
            outst++;
            granted[s] = 1'b1;
         end
         if (rst_i) begin
            rr_m  = 0;
            outst = 0;
            err_m = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT presents a response.
   always @(negedge clk) begin
      sb_t e;
      logic [MP-1:0] ev;
      #1;
      if (mdl_on && in_r_valid != '0) begin
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", in_r_valid, '0);
         end else begin
            e  = sb_q.pop_front();
            ev = '0;
            ev[e.port] = 1'b1;
            chk("rsp_route", in_r_valid, ev);
            for (int p = 0; p < MP; p++) chk("rsp_data", in_r_data[p], e.data);
         end
      end
   end

   task automatic step(input int req_pct, input int gnt_pct);
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < MP; p++) begin
         if (granted[p]) begin
            in_req[p]  = 1'b0;
            granted[p] = 1'b0;
         end
         if (!in_req[p] && $urandom_range(99) < req_pct) begin
            in_req[p]  = 1'b1;
            in_add[p]  = $urandom;
            in_wen[p]  = 1'($urandom);
            in_be[p]   = BW'($urandom);
            in_data[p] = $urandom;
         end
      end
      out_gnt = ($urandom_range(99) < gnt_pct);
      if (spur) begin
         out_r_valid = 1'b1;
         out_r_data  = $urandom;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         out_r_valid = 1'b1;
         out_r_data  = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end else begin
         out_r_valid = 1'b0;
         out_r_data  = $urandom;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((in_req != '0 || outst != 0 || rsp_q.size() != 0) && n < 1000) begin
         step(0, 100);
         n++;
      end
      chk("drain_done", n < 1000, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
      out_gnt = 1'b0; out_r_valid = 1'b0; out_r_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_i  = 1'b0;
      mdl_on = 1'b1;

      lat_min = 1;  lat_max = 3;  repeat (1500) step(60, 80);
      lat_min = 10; lat_max = 10; repeat (300)  step(100, 100);
      lat_min = 1;  lat_max = 6;  repeat (800)  step(50, 30);
      lat_min = 1;  lat_max = 1;  repeat (300)  step(90, 100);
      drain();

      spur = 1'b1;
      step(0, 100);
      spur = 1'b0;
      repeat (4) step(0, 100);
      rst_i = 1'b1;
      step(0, 100);
      rst_i = 1'b0;
      repeat (3) step(0, 100);

      lat_min = 1; lat_max = 4; repeat (400) step(70, 70);
      drain();
      repeat (2) step(0, 100);
      chk("sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
